// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO between the host write side and the UART TX parallel interface.
// Optional sticky overflow/underflow status is enabled by defining UART_TX_FIFO_STATUS_EN.
module uart_tx_fifo #(
  parameter int DEPTH        = 16,
  parameter int WIDTH        = 9,
  parameter int AFULL_THRESH = 12
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_wr_valid,
  output logic                     o_wr_ready,
  output logic [WIDTH-1:0]         o_tx_parallel,
  output logic                     o_tx_valid,
  input  logic                     i_tx_ready,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_almost_full,
`ifdef UART_TX_FIFO_STATUS_EN
  output logic                     o_empty,
  input  logic                     i_clear_flags,
  output logic                     o_overflow,
  output logic                     o_underflow
`else
  output logic                     o_empty
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push;
  logic             pop;

  always_comb begin
    o_wr_ready    = (count != CW'(DEPTH));
    o_tx_valid    = (count != '0);
    o_empty       = (count == '0);
    o_count       = count;
    o_almost_full = (count >= CW'(AFULL_THRESH));
    o_tx_parallel = mem[rd_ptr];
    push          = i_wr_valid && o_wr_ready;
    pop           = o_tx_valid && i_tx_ready;
  end

  // Storage carries no reset so it can map onto distributed RAM.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && push) begin
      mem[wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

`ifdef UART_TX_FIFO_STATUS_EN
  logic ovf_set;
  logic udf_set;

  always_comb begin
    ovf_set = i_wr_valid && (count == CW'(DEPTH));
    udf_set = i_tx_ready && (count == '0);
  end

  // Set takes priority over a same-cycle clear.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      o_overflow  <= ovf_set || (o_overflow  && !i_clear_flags);
      o_underflow <= udf_set || (o_underflow && !i_clear_flags);
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized self-checking bench for uart_tx_fifo against a queue-based model.
// Status-flag checks apply only when UART_TX_FIFO_STATUS_EN is defined.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int WIDTH = 9;
  localparam int AFULL = 12;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] wr_data = '0;
  logic             wr_valid = 1'b0;
  logic             wr_ready;
  logic [WIDTH-1:0] tx_parallel;
  logic             tx_valid;
  logic             tx_ready = 1'b0;
  logic [4:0]       count;
  logic             almost_full;
  logic             empty;
  logic             clear_flags = 1'b0;
  logic             overflow;
  logic             underflow;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [WIDTH-1:0] q[$];
  logic             exp_ovf = 1'b0;
  logic             exp_udf = 1'b0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AFULL_THRESH(AFULL)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_wr_data     (wr_data),
    .i_wr_valid    (wr_valid),
    .o_wr_ready    (wr_ready),
    .o_tx_parallel (tx_parallel),
    .o_tx_valid    (tx_valid),
    .i_tx_ready    (tx_ready),
    .o_count       (count),
    .o_almost_full (almost_full),
`ifdef UART_TX_FIFO_STATUS_EN
    .o_empty       (empty),
    .i_clear_flags (clear_flags),
    .o_overflow    (overflow),
    .o_underflow   (underflow)
`else
    .o_empty       (empty)
`endif
  );

`ifndef UART_TX_FIFO_STATUS_EN
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_state();
    int unsigned n;
    n = q.size();
    check("count", 32'(count), n);
    check("empty", 32'(empty), 32'(n == 0));
    check("tx_valid", 32'(tx_valid), 32'(n != 0));
    check("wr_ready", 32'(wr_ready), 32'(n != DEPTH));
    check("almost_full", 32'(almost_full), 32'(n >= AFULL));
    if (n != 0) check("tx_parallel", 32'(tx_parallel), 32'(q[0]));
`ifdef UART_TX_FIFO_STATUS_EN
    check("overflow", 32'(overflow), 32'(exp_ovf));
    check("underflow", 32'(underflow), 32'(exp_udf));
`endif
  endtask

  // Called at a falling edge: check, drive, advance one clock, update the model.
  task automatic cycle(input logic wv, input logic [WIDTH-1:0] wd, input logic tr, input logic clr);
    logic do_push;
    logic do_pop;
    check_state();
    wr_valid    = wv;
    wr_data     = wd;
    tx_ready    = tr;
    clear_flags = clr;
    do_push = wv && (q.size() < DEPTH);
    do_pop  = tr && (q.size() > 0);
    @(posedge clk);
    exp_ovf = (wv && q.size() == DEPTH) || (exp_ovf && !clr);
    exp_udf = (tr && q.size() == 0) || (exp_udf && !clr);
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back(wd);
    @(negedge clk);
    wr_valid    = 1'b0;
    tx_ready    = 1'b0;
    clear_flags = 1'b0;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    wr_valid    = 1'($urandom_range(0, 1));
    wr_data     = WIDTH'($urandom_range(0, 511));
    tx_ready    = 1'($urandom_range(0, 1));
    clear_flags = 1'($urandom_range(0, 1));
    @(posedge clk);
    q.delete();
    exp_ovf = 1'b0;
    exp_udf = 1'b0;
    @(negedge clk);
    rst_n       = 1'b1;
    wr_valid    = 1'b0;
    tx_ready    = 1'b0;
    clear_flags = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    do_reset();

    // Idle with TX demanding: nothing may move.
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    check("idle_count", 32'(count), 32'd0);

    // Single word latency and one pop.
    cycle(1'b1, 9'h155, 1'b0, 1'b0);
    check("single_head", 32'(tx_parallel), 32'h155);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("single_drained", 32'(empty), 32'd1);

    // Fill to full, refused 17th write, then clear flags.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, WIDTH'(i), 1'b0, 1'b0);
    check("full_count", 32'(count), 32'd16);
    cycle(1'b1, 9'h0FF, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1);

    // Full with simultaneous push and pop: push refused, retried next cycle.
    cycle(1'b1, 9'h1AA, 1'b1, 1'b0);
    check("full_pop_count", 32'(count), 32'd15);
    cycle(1'b1, 9'h1AA, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, '0, 1'b1, 1'b0);

    // Steady state at count=3 across pointer wrap.
    for (int i = 0; i < 3; i++) cycle(1'b1, WIDTH'(9'h100 + i), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) cycle(1'b1, WIDTH'($urandom_range(0, 511)), 1'b1, 1'b0);
    check("wrap_count", 32'(count), 32'd3);

    // Reset with count=7 discards everything; stale data must not reappear.
    for (int i = 0; i < 4; i++) cycle(1'b1, WIDTH'(9'h0A0 + i), 1'b0, 1'b0);
    check("pre_reset_count", 32'(count), 32'd7);
    do_reset();
    check("post_reset_count", 32'(count), 32'd0);
    check("post_reset_valid", 32'(tx_valid), 32'd0);
    cycle(1'b1, 9'h033, 1'b0, 1'b0);
    check("post_reset_head", 32'(tx_parallel), 32'h033);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 99) < 55), WIDTH'($urandom_range(0, 511)),
            1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 99) < 5));
    end
    check_state();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Synchronous FIFO that buffers parallel words from the host/bus side and feeds them to the UART transmitter's parallel interface (i_tx_parallel / i_tx_valid / o_ready).
- Lets the producer burst several words while the transmitter serialises one frame at a time.
- Single clock domain (i_clk). Sits directly upstream of the UART TX stage.

Parameters:
- DEPTH, 16, number of entries; power of two, minimum 2.
- WIDTH, 9, word width; matches the TX maximum word size.
- AFULL_THRESH, 12, o_almost_full asserts when count >= AFULL_THRESH; legal range 1..DEPTH.

Ports:
- i_clk  input  1  clock
- i_rst_n  input  1  reset, synchronous, active-low
- i_wr_data  input  WIDTH  word to enqueue
- i_wr_valid  input  1  producer has a word
- o_wr_ready  output  1  FIFO can accept a word (not full)
- o_tx_parallel  output  WIDTH  head-of-queue word, to TX i_tx_parallel
- o_tx_valid  output  1  head word valid, to TX i_tx_valid
- i_tx_ready  input  1  TX accepts a word, from TX o_ready
- o_count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- o_almost_full  output  1  count >= AFULL_THRESH
- o_empty  output  1  count == 0
- i_clear_flags  input  1  clears sticky flags (present only with UART_TX_FIFO_STATUS_EN)
- o_overflow  output  1  sticky overflow (present only with UART_TX_FIFO_STATUS_EN)
- o_underflow  output  1  sticky underflow (present only with UART_TX_FIFO_STATUS_EN)

Behaviour:
- Reset (i_rst_n low at a rising edge of i_clk) sets:
  - write pointer and read pointer to 0; count to 0
  - o_tx_valid=0, o_empty=1, o_wr_ready=1, o_almost_full=0, o_count=0, o_overflow=0, o_underflow=0
  - Storage contents are not reset. o_tx_parallel is don't-care while o_tx_valid=0.
  - Inputs are ignored during reset. Reset mid-burst discards all queued words.
- Output derivation: all outputs are derived only from registered state (pointers, count, storage, flags). There is no combinational input-to-output path.
  - o_wr_ready = (count != DEPTH)
  - o_tx_valid = (count != 0)
  - o_empty = (count == 0)
  - o_tx_parallel = mem[rd_ptr]
- Push: occurs when i_wr_valid && o_wr_ready.
  - mem[wr_ptr] <= i_wr_data; wr_ptr increments modulo DEPTH (natural wrap).
- Pop: occurs when o_tx_valid && i_tx_ready. rd_ptr increments modulo DEPTH.
  - The TX stage holds o_ready high for exactly the capture cycle, so each accepted word pops exactly once.
- Count update per cycle:
  - +1 on push only
  - -1 on pop only
  - unchanged when push and pop occur together, or when neither occurs.
- Latency: a word pushed into an empty FIFO gives o_tx_valid=1 on the next cycle. There is no same-cycle fall-through.
- Full + simultaneous pop: o_wr_ready is already 0, so the write is refused even though a slot frees this cycle. The producer retries; the write is accepted on the next cycle.
- Empty + i_tx_ready: no pop. Pointers and count are unchanged.
- Ordering: strict FIFO; no reordering or duplication.
- Data is passed unmodified. Word-size masking is the TX stage's responsibility.

Optional Feature:
Macro UART_TX_FIFO_STATUS_EN.
- Defined: adds ports i_clear_flags, o_overflow, o_underflow.
  - o_overflow sets when i_wr_valid && count==DEPTH.
  - o_underflow sets when i_tx_ready && count==0 && a host read strobe is attempted. In this block that strobe is i_tx_ready while empty, but only in a cycle where the TX stage also asserts i_tx_valid-equivalent demand. Implemented as: sets when i_tx_ready && !o_tx_valid for 2+ consecutive cycles is NOT required; simply i_tx_ready && count==0.
  - Both flags are sticky until i_clear_flags=1 or reset.
  - If set and clear occur in the same cycle, set wins.
  - The refused word is dropped; FIFO state is unchanged.
- Not defined: these ports and registers do not exist. A write attempted while full is silently refused via o_wr_ready=0.

Test Plan:
- Reset then idle: o_empty=1, o_wr_ready=1, o_tx_valid=0, o_count=0; i_tx_ready=1 for 5 cycles causes no pointer change.
- Push 0x155 with i_tx_ready=0: next cycle o_tx_valid=1, o_tx_parallel=0x155, o_count=1. Pulse i_tx_ready for 1 cycle: next cycle o_empty=1.
- Push 16 words 0x000..0x00F (DEPTH=16, i_tx_ready=0):
  - o_almost_full rises when o_count=12; o_wr_ready=0 at o_count=16.
  - A 17th push is refused and o_overflow=1 (macro on).
  - Words then drain in order 0x000..0x00F.
- At count=16, assert push 0x1AA together with pop: count goes to 15 and the push is refused. The push is retried next cycle and accepted; 0x1AA exits last.
- Wrap: run 40 push/pop cycles with simultaneous push+pop at count=3. o_count stays 3 and the output sequence matches the input sequence across pointer wrap.
- Reset asserted with count=7: next cycle count=0 and o_tx_valid=0; stale data does not reappear after the next push.
